key_debounce_repeat: RTL and testbench

//   Conditions the raw DE10-Lite push-buttons (active-low, bouncy, asynchronous) into clean
//   per-key signals. Sits directly upstream of the 7-segment display path: its press pulses

---
 rtl/key_debounce_repeat.sv | 154 +++++++++++++++
 tb/tb_key_debounce_repeat.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_repeat.sv
// Push-button conditioner: 2-FF sync, debounce, hold-to-repeat.
// Per key: debounced level, press pulse (with repeat), release pulse.
module key_debounce_repeat #(
   parameter int N_KEYS              = 2,
   parameter int DEBOUNCE_CYCLES     = 500_000,
   parameter int REPEAT_DELAY_CYCLES = 25_000_000,
   parameter int REPEAT_RATE_CYCLES  = 5_000_000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_KEYS-1:0] key_n,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release
);

   localparam int MAX_A =
      (DEBOUNCE_CYCLES > REPEAT_DELAY_CYCLES) ?
      DEBOUNCE_CYCLES : REPEAT_DELAY_CYCLES;
   localparam int MAX_P =
      (MAX_A > REPEAT_RATE_CYCLES) ? MAX_A : REPEAT_RATE_CYCLES;
   localparam int CW = $clog2(MAX_P) + 1;

   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] DLY_LAST =
      CW'((REPEAT_DELAY_CYCLES == 0) ? 0 : REPEAT_DELAY_CYCLES - 1);
   localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_RATE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = '1;
   localparam logic          RPT_EN   = (REPEAT_DELAY_CYCLES != 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DEB_P,
      S_HELD_DLY,
      S_HELD_RPT,
      S_DEB_R
   } state_t;

   logic [N_KEYS-1:0] r_sync1;
   logic [N_KEYS-1:0] r_sync2;
   logic [N_KEYS-1:0] w_s;

   // Two-stage synchronizer; resets to "released"
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
      end else begin
         r_sync1 <= key_n;
         r_sync2 <= r_sync1;
      end
   end

   assign w_s = ~r_sync2;

   for (genvar g = 0; g < N_KEYS; g++) begin : g_key
      state_t        r_state;
      state_t        w_state_nxt;
      logic [CW-1:0] r_cnt;
      logic [CW-1:0] w_cnt_nxt;
      logic          r_level;
      logic          w_level_nxt;
      logic          r_press;
      logic          w_press_nxt;
      logic          r_rel;
      logic          w_rel_nxt;

      // State, counter and registered outputs
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_rel   <= 1'b0;
         end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_press <= w_press_nxt;
            r_rel   <= w_rel_nxt;
         end
      end

      // Next state; every transition reloads the counter
      always_comb begin
         w_state_nxt = r_state;
         w_cnt_nxt   = r_cnt + 1'b1;
         w_level_nxt = r_level;
         w_press_nxt = 1'b0;
         w_rel_nxt   = 1'b0;
         unique case (r_state)
            S_IDLE: begin
               w_level_nxt = 1'b0;
               w_cnt_nxt   = '0;
               if (w_s[g]) w_state_nxt = S_DEB_P;
            end
            S_DEB_P: begin
               if (!w_s[g]) begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = '0;
               end else if (r_cnt == DEB_LAST) begin
                  w_state_nxt = S_HELD_DLY;
                  w_cnt_nxt   = '0;
                  w_level_nxt = 1'b1;
                  w_press_nxt = 1'b1;
               end
            end
            S_HELD_DLY: begin
               if (!w_s[g]) begin
                  w_state_nxt = S_DEB_R;
                  w_cnt_nxt   = '0;
               end else if (RPT_EN && r_cnt == DLY_LAST) begin
                  w_state_nxt = S_HELD_RPT;
                  w_cnt_nxt   = '0;
                  w_press_nxt = 1'b1;
               end else if (r_cnt == CNT_MAX) begin
                  w_cnt_nxt   = r_cnt;
               end
            end
            S_HELD_RPT: begin
               if (!w_s[g]) begin
                  w_state_nxt = S_DEB_R;
                  w_cnt_nxt   = '0;
               end else if (r_cnt == RPT_LAST) begin
                  w_cnt_nxt   = '0;
                  w_press_nxt = 1'b1;
               end
            end
            S_DEB_R: begin
               if (w_s[g]) begin
                  w_state_nxt = S_HELD_DLY;
                  w_cnt_nxt   = '0;
               end else if (r_cnt == DEB_LAST) begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = '0;
                  w_level_nxt = 1'b0;
                  w_rel_nxt   = 1'b1;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               w_level_nxt = 1'b0;
            end
         endcase
      end

      assign key_level[g]   = r_level;
      assign key_press[g]   = r_press;
      assign key_release[g] = r_rel;
   end

endmodule

// File: tb/tb_key_debounce_repeat.sv
// Bench for key_debounce_repeat: run-length reference model,
// event scoreboard, directed cases then random key activity.
module tb_key_debounce_repeat;

   localparam int DEB  = 4;
   localparam int DEB1 = 1;
   localparam int RD   = 20;
   localparam int RR   = 5;
   localparam int NK   = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] kn0 = 2'b11;
   logic [1:0] kn1 = 2'b11;
   logic [1:0] lv0, pr0, rl0;
   logic [1:0] lv1, pr1, rl1;
   logic [3:0] kn_all, lv_all, pr_all, rl_all;

   assign kn_all = {kn1, kn0};
   assign lv_all = {lv1, lv0};
   assign pr_all = {pr1, pr0};
   assign rl_all = {rl1, rl0};

   always #5 clk = ~clk;

   key_debounce_repeat #(
      .N_KEYS(NK), .DEBOUNCE_CYCLES(DEB),
      .REPEAT_DELAY_CYCLES(RD), .REPEAT_RATE_CYCLES(RR)
   ) u_dut0 (
      .clk(clk), .reset(reset), .key_n(kn0),
      .key_level(lv0), .key_press(pr0), .key_release(rl0)
   );

   key_debounce_repeat #(
      .N_KEYS(NK), .DEBOUNCE_CYCLES(DEB1),
      .REPEAT_DELAY_CYCLES(RD), .REPEAT_RATE_CYCLES(RR)
   ) u_dut1 (
      .clk(clk), .reset(reset), .key_n(kn1),
      .key_level(lv1), .key_press(pr1), .key_release(rl1)
   );

   typedef struct {
      int         cyc;
      logic [3:0] pr;
      logic [3:0] rl;
   } ev_t;

   ev_t q[$];
   ev_t mev;
   ev_t sev;
   int  errors = 0;
   int  checks = 0;
   int  cyc = 0;

   // reference model state: delay line and run lengths per key
   logic [3:0] d1, d2, exp_lvl;
   logic [3:0] m_pr, m_rl;
   logic       m_s;
   int         ones[4], zeros[4], anchor[4];
   bit         held[4];

   function automatic int deb_of(input int k);
      return (k < 2) ? DEB : DEB1;
   endfunction

   function automatic bit repeat_due(input int k_since);
      if (RD == 0) return 1'b0;
      if (k_since == RD) return 1'b1;
      return (k_since > RD) && (((k_since - RD) % RR) == 0);
   endfunction

   // model: a press is a run of deb+1 pressed samples while released,
   // a release is a run of deb+1 released samples while pressed,
   // repeats fall at anchor+RD+n*RR while held without interruption
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         d1 = '0;
         d2 = '0;
         exp_lvl = '0;
         for (int k = 0; k < 4; k++) begin
            ones[k] = 0;
            zeros[k] = 0;
            anchor[k] = 0;
            held[k] = 1'b0;
         end
      end else begin
         cyc++;
         m_pr = '0;
         m_rl = '0;
         for (int k = 0; k < 4; k++) begin
            m_s = d2[k];
            if (m_s) begin
               ones[k]++;
               zeros[k] = 0;
            end else begin
               zeros[k]++;
               ones[k] = 0;
            end
            if (!exp_lvl[k]) begin
               if (ones[k] == deb_of(k) + 1) begin
                  exp_lvl[k] = 1'b1;
                  m_pr[k] = 1'b1;
                  held[k] = 1'b1;
                  anchor[k] = cyc;
               end
            end else if (m_s) begin
               if (!held[k]) begin
                  held[k] = 1'b1;
                  anchor[k] = cyc;
               end else if (repeat_due(cyc - anchor[k])) begin
                  m_pr[k] = 1'b1;
               end
            end else begin
               held[k] = 1'b0;
               if (zeros[k] == deb_of(k) + 1) begin
                  exp_lvl[k] = 1'b0;
                  m_rl[k] = 1'b1;
               end
            end
         end
         d2 = d1;
         d1 = ~kn_all;
         if ((m_pr | m_rl) != 4'b0) begin
            mev.cyc = cyc;
            mev.pr = m_pr;
            mev.rl = m_rl;
            q.push_back(mev);
         end
      end
   end

   int lp[4] = '{-1000, -1000, -1000, -1000};
   int lr[4] = '{-1000, -1000, -1000, -1000};
   int npress[4] = '{0, 0, 0, 0};
   int nrel[4] = '{0, 0, 0, 0};

   // monitor: level every cycle, pulses against queued events
   always @(negedge clk) begin
      checks++;
      if (lv_all !== exp_lvl) begin
         errors++;
         $display("FAIL level cyc=%0d got=%b exp=%b",
                  cyc, lv_all, exp_lvl);
      end
      while (q.size() > 0 && q[0].cyc < cyc) begin
         checks++;
         errors++;
         sev = q.pop_front();
         $display("FAIL missed_event cyc=%0d got=none exp_pr=%b exp_rl=%b",
                  sev.cyc, sev.pr, sev.rl);
      end
      if ((pr_all | rl_all) != 4'b0) begin
         for (int k = 0; k < 4; k++) begin
            if (pr_all[k]) begin
               lp[k] = cyc;
               npress[k]++;
            end
            if (rl_all[k]) begin
               lr[k] = cyc;
               nrel[k]++;
            end
         end
         checks++;
         if (q.size() == 0 || q[0].cyc != cyc) begin
            errors++;
            $display("FAIL spurious_pulse cyc=%0d got_pr=%b got_rl=%b exp=none",
                     cyc, pr_all, rl_all);
         end else begin
            sev = q.pop_front();
            if (sev.pr !== pr_all || sev.rl !== rl_all) begin
               errors++;
               $display("FAIL pulse cyc=%0d got_pr=%b got_rl=%b exp_pr=%b exp_rl=%b",
                        cyc, pr_all, rl_all, sev.pr, sev.rl);
            end
         end
      end else if (q.size() > 0 && q[0].cyc == cyc) begin
         checks++;
         errors++;
         sev = q.pop_front();
         $display("FAIL missing_pulse cyc=%0d got=none exp_pr=%b exp_rl=%b",
                  cyc, sev.pr, sev.rl);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #2;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", name, act, exp);
      end
   endtask

   int         t0, tf, np, nr;
   int         rem[4];
   logic [3:0] kv;

   initial begin
      #1 reset = 1'b0;
      tick(3);
      reset = 1'b1;
      tick(3);

      // clean press
      t0 = cyc;
      kn0[0] = 1'b0;
      tick(10);
      chk("t1_press_lat", lp[0] - t0, DEB + 3);
      chk("t1_level", int'(lv0[0]), 1);
      chk("t1_key1_silent", npress[1], 0);
      kn0[0] = 1'b1;
      tick(15);

      // bounce on press
      np = npress[0];
      kn0[0] = 1'b0; tick(2);
      kn0[0] = 1'b1; tick(1);
      kn0[0] = 1'b0; tick(2);
      kn0[0] = 1'b1; tick(10);
      chk("t2_no_press", npress[0] - np, 0);

      // auto-repeat
      np = npress[0];
      kn0[0] = 1'b0;
      tick(60);
      chk("t3_repeat_count", npress[0] - np,
          2 + (60 - (DEB + 3 + RD)) / RR);
      kn0[0] = 1'b1;
      tick(15);

      // release with bounce
      kn0[0] = 1'b0;
      tick(10);
      nr = nrel[0];
      kn0[0] = 1'b1; tick(2);
      kn0[0] = 1'b0; tick(1);
      kn0[0] = 1'b1;
      tf = cyc;
      tick(15);
      chk("t4_release_lat", lr[0] - tf, DEB + 3);
      chk("t4_one_release", nrel[0] - nr, 1);
      chk("t4_level_low", int'(lv0[0]), 0);

      // reset mid-hold
      kn0[0] = 1'b0;
      tick(10);
      chk("t5_held", int'(lv0[0]), 1);
      nr = nrel[0];
      reset = 1'b0;
      #1;
      chk("t5_async_clear", int'({lv_all, pr_all, rl_all}), 0);
      kn0[0] = 1'b1;
      tick(1);
      reset = 1'b1;
      tick(4);
      chk("t5_no_release", nrel[0] - nr, 0);
      t0 = cyc;
      kn0[0] = 1'b0;
      tick(10);
      chk("t5_repress_lat", lp[0] - t0, DEB + 3);
      kn0[0] = 1'b1;
      tick(15);

      // simultaneous keys, plus DEBOUNCE_CYCLES=1 instance
      t0 = cyc;
      kn0 = 2'b00;
      kn1 = 2'b00;
      tick(10);
      chk("t6_k0_lat", lp[0] - t0, DEB + 3);
      chk("t6_k1_lat", lp[1] - t0, DEB + 3);
      chk("t6_d1_k0_lat", lp[2] - t0, DEB1 + 3);
      chk("t6_d1_k1_lat", lp[3] - t0, DEB1 + 3);
      kn0 = 2'b11;
      kn1 = 2'b11;
      tick(15);

      // random activity, mixing short bounces and long holds
      for (int k = 0; k < 4; k++) rem[k] = 0;
      for (int c = 0; c < 2000; c++) begin
         kv = {kn1, kn0};
         for (int k = 0; k < 4; k++) begin
            if (rem[k] == 0) begin
               kv[k] = ~kv[k];
               rem[k] = ($urandom_range(0, 2) == 0) ?
                        int'($urandom_range(20, 70)) :
                        int'($urandom_range(1, 8));
            end
            rem[k]--;
         end
         {kn1, kn0} = kv;
         if (c == 1000) begin
            reset = 1'b0;
            #1;
            chk("rnd_async_clear", int'({lv_all, pr_all, rl_all}), 0);
            tick(1);
            reset = 1'b1;
         end
         tick(1);
      end
      kn0 = 2'b11;
      kn1 = 2'b11;
      tick(40);
      chk("all_released", int'(lv_all), 0);
      chk("queue_empty", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
